uart_fifo_controller: RTL and testbench

Buffered, runtime-configurable UART with an AHB slave register port. It is the next-generation serial peripheral: parameterised character width and FIFO depth, with software-selectable parity, stop bits and baud divisor. Status flags are sticky and interrupts are maskable. It sits on the AHB peripheral bus beside the other slaves and drives one TX/RX pin pair.

---
 rtl/uart_fifo_controller.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_controller.sv
// UART with TX/RX FIFOs, sticky status, maskable interrupt and an AHB slave port.
// Each FSM latches baud divisor and frame format when a frame starts.

module uart_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + ONE;
            if (pop)  rp <= rp + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end

    assign dout  = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

module uart_fifo_controller #(
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 50000000,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          haddr_ahb,
    input  logic [31:0]          hwdata_ahb,
    output logic [31:0]          hrdata_ahb,
    input  logic                 hwrite_ahb,
    input  logic [1:0]           htrans_ahb,
    input  logic                 hsel_ahb,
    output logic                 hready_out_ahb,
    output logic                 hresp_ahb,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] test_out,
    output logic                 uart_irq
);
    localparam int          DW       = DATA_BITS;
    localparam logic [15:0] BAUD_RST = 16'(CLK_FREQ / BAUD_RATE);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    logic          ap_valid, ap_write;
    logic [2:0]    ap_sel;
    logic [4:0]    ctrl;
    logic [15:0]   baud;
    logic [2:0]    irq_en;
    logic [3:0]    sticky, sticky_set;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [DW-1:0] tx_head, rx_head;
    logic          rd, wr, rx_good, par_set, frm_set;
    logic          unused_bits;

    assign hready_out_ahb = 1'b1;
    assign hresp_ahb      = 1'b0;
    assign unused_bits    = ^{haddr_ahb[31:5], haddr_ahb[1:0],
                              hwdata_ahb[31:16], htrans_ahb[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ap_valid <= 1'b0;
            ap_write <= 1'b0;
            ap_sel   <= '0;
        end else begin
            ap_valid <= hsel_ahb & htrans_ahb[1];
            ap_write <= hwrite_ahb;
            ap_sel   <= haddr_ahb[4:2];
        end
    end

    assign wr = ap_valid & ap_write;
    assign rd = ap_valid & ~ap_write;

    // A full FIFO still accepts a push when it is popped in the same cycle.
    assign tx_push = wr && ap_sel == 3'd0 && (!tx_full || tx_pop);
    assign rx_pop  = rd && ap_sel == 3'd0 && !rx_empty;
    assign rx_push = rx_good && (!rx_full || rx_pop);
    assign sticky_set = {wr && ap_sel == 3'd0 && tx_full && !tx_pop,
                         frm_set, par_set, rx_good && rx_full && !rx_pop};

    uart_fifo_buf #(.W(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop),
        .din(hwdata_ahb[DW-1:0]), .dout(tx_head),
        .full(tx_full), .empty(tx_empty)
    );

    logic [DW-1:0] rx_sh, rx_sh_n;

    uart_fifo_buf #(.W(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop),
        .din(rx_sh), .dout(rx_head),
        .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= 5'h03;
            baud     <= BAUD_RST;
            irq_en   <= '0;
            sticky   <= '0;
            uart_irq <= 1'b0;
            test_out <= '0;
        end else begin
            if (wr && ap_sel == 3'd2) ctrl <= hwdata_ahb[4:0];
            if (wr && ap_sel == 3'd3)
                baud <= (hwdata_ahb[15:0] < 16'd4) ? 16'd4 : hwdata_ahb[15:0];
            if (wr && ap_sel == 3'd4) irq_en <= hwdata_ahb[2:0];
            sticky <= (sticky & ~((wr && ap_sel == 3'd1) ? hwdata_ahb[8:5] : 4'b0))
                    | sticky_set;
            uart_irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty)
                      | (irq_en[2] & |sticky);
            if (rx_good) test_out <= rx_sh;
        end
    end

    tx_state_t     tx_st, tx_st_n;
    logic [15:0]   tx_cnt, tx_cnt_n, tx_bd, tx_bd_n;
    logic [DW-1:0] tx_sh, tx_sh_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic          tx_par, tx_par_n, tx_pe, tx_pe_n, tx_ts, tx_ts_n, tx_n;
    logic          tx_done;

    always_comb begin
        hrdata_ahb = '0;
        if (rd) begin
            unique case (1'b1)
                ap_sel == 3'd0: hrdata_ahb[DW-1:0] = rx_empty ? '0 : rx_head;
                ap_sel == 3'd1: hrdata_ahb[8:0] = {sticky, tx_st != TX_IDLE,
                                    rx_empty, rx_full, tx_empty, tx_full};
                ap_sel == 3'd2: hrdata_ahb[4:0]  = ctrl;
                ap_sel == 3'd3: hrdata_ahb[15:0] = baud;
                ap_sel == 3'd4: hrdata_ahb[2:0]  = irq_en;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st  <= TX_IDLE;
            tx_cnt <= '0;
            tx_bd  <= BAUD_RST;
            tx_sh  <= '0;
            tx_bit <= '0;
            tx_par <= 1'b0;
            tx_pe  <= 1'b0;
            tx_ts  <= 1'b0;
            tx     <= 1'b1;
        end else begin
            tx_st  <= tx_st_n;
            tx_cnt <= tx_cnt_n;
            tx_bd  <= tx_bd_n;
            tx_sh  <= tx_sh_n;
            tx_bit <= tx_bit_n;
            tx_par <= tx_par_n;
            tx_pe  <= tx_pe_n;
            tx_ts  <= tx_ts_n;
            tx     <= tx_n;
        end
    end

    assign tx_done = (tx_cnt == 16'd0);

    always_comb begin
        tx_st_n  = tx_st;
        tx_cnt_n = tx_done ? tx_bd - 16'd1 : tx_cnt - 16'd1;
        tx_bd_n  = tx_bd;
        tx_sh_n  = tx_sh;
        tx_bit_n = tx_bit;
        tx_par_n = tx_par;
        tx_pe_n  = tx_pe;
        tx_ts_n  = tx_ts;
        tx_n     = tx;
        tx_pop   = 1'b0;
        case (tx_st)
            TX_IDLE: begin
                tx_n = 1'b1;
                if (ctrl[0] && !tx_empty) begin
                    tx_pop   = 1'b1;
                    tx_sh_n  = tx_head;
                    tx_par_n = ^tx_head ^ ctrl[3];
                    tx_pe_n  = ctrl[2];
                    tx_ts_n  = ctrl[4];
                    tx_bd_n  = baud;
                    tx_cnt_n = baud - 16'd1;
                    tx_n     = 1'b0;
                    tx_st_n  = TX_START;
                end
            end
            TX_START: if (tx_done) begin
                tx_st_n  = TX_DATA;
                tx_bit_n = '0;
                tx_n     = tx_sh[0];
            end
            TX_DATA: if (tx_done) begin
                if (tx_bit == LAST_BIT) begin
                    tx_st_n = tx_pe ? TX_PARITY : TX_STOP1;
                    tx_n    = tx_pe ? tx_par : 1'b1;
                end else begin
                    tx_bit_n = tx_bit + 3'd1;
                    tx_sh_n  = tx_sh >> 1;
                    tx_n     = tx_sh[1];
                end
            end
            TX_PARITY: if (tx_done) begin
                tx_st_n = TX_STOP1;
                tx_n    = 1'b1;
            end
            TX_STOP1: if (tx_done) tx_st_n = tx_ts ? TX_STOP2 : TX_IDLE;
            TX_STOP2: if (tx_done) tx_st_n = TX_IDLE;
            default:  tx_st_n = TX_IDLE;
        endcase
    end

    rx_state_t   rx_st, rx_st_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_bd, rx_bd_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic        rx_s1, rx_s2, rx_prev, rx_done;
    logic        rx_pe, rx_pe_n, rx_po, rx_po_n, rx_pbad, rx_pbad_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            rx_st   <= RX_IDLE;
            rx_cnt  <= '0;
            rx_bd   <= BAUD_RST;
            rx_sh   <= '0;
            rx_bit  <= '0;
            rx_pe   <= 1'b0;
            rx_po   <= 1'b0;
            rx_pbad <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_st   <= rx_st_n;
            rx_cnt  <= rx_cnt_n;
            rx_bd   <= rx_bd_n;
            rx_sh   <= rx_sh_n;
            rx_bit  <= rx_bit_n;
            rx_pe   <= rx_pe_n;
            rx_po   <= rx_po_n;
            rx_pbad <= rx_pbad_n;
        end
    end

    assign rx_done = (rx_cnt == 16'd0);

    always_comb begin
        rx_st_n   = rx_st;
        rx_cnt_n  = rx_done ? rx_bd - 16'd1 : rx_cnt - 16'd1;
        rx_bd_n   = rx_bd;
        rx_sh_n   = rx_sh;
        rx_bit_n  = rx_bit;
        rx_pe_n   = rx_pe;
        rx_po_n   = rx_po;
        rx_pbad_n = rx_pbad;
        rx_good   = 1'b0;
        par_set   = 1'b0;
        frm_set   = 1'b0;
        case (rx_st)
            RX_IDLE: if (ctrl[1] && rx_prev && !rx_s2) begin
                rx_bd_n   = baud;
                rx_cnt_n  = {1'b0, baud[15:1]} - 16'd1;
                rx_pe_n   = ctrl[2];
                rx_po_n   = ctrl[3];
                rx_pbad_n = 1'b0;
                rx_st_n   = RX_START;
            end
            RX_START: if (rx_done) begin
                rx_st_n  = rx_s2 ? RX_IDLE : RX_DATA;
                rx_bit_n = '0;
            end
            RX_DATA: if (rx_done) begin
                rx_sh_n = {rx_s2, rx_sh[DW-1:1]};
                if (rx_bit == LAST_BIT) rx_st_n = rx_pe ? RX_PARITY : RX_STOP;
                else rx_bit_n = rx_bit + 3'd1;
            end
            RX_PARITY: if (rx_done) begin
                rx_pbad_n = rx_s2 ^ (^rx_sh) ^ rx_po;
                rx_st_n   = RX_STOP;
            end
            RX_STOP: if (rx_done) begin
                rx_st_n = RX_IDLE;
                frm_set = ~rx_s2;
                rx_good = rx_s2;
                par_set = rx_s2 & rx_pbad;
            end
            default: rx_st_n = RX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed-plus-random bench for uart_fifo_controller; frames and FIFO
// contents are predicted from the serial format rules and a queue model.

module tb_uart_fifo_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0, hrdata;
    logic        hwrite = 1'b0, hsel = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic        hready, hresp, tx, rx, irq;
    logic [7:0]  test_out;
    logic        rx_drv = 1'b1, loop_en = 1'b0;

    int checks = 0;
    int failures = 0;
    bit fbits[$];
    bit trace[0:255];
    logic [7:0] model_q[$];

    assign rx = loop_en ? tx : rx_drv;

    uart_fifo_controller dut (
        .clk(clk), .rst_n(rst_n),
        .haddr_ahb(haddr), .hwdata_ahb(hwdata), .hrdata_ahb(hrdata),
        .hwrite_ahb(hwrite), .htrans_ahb(htrans), .hsel_ahb(hsel),
        .hready_out_ahb(hready), .hresp_ahb(hresp),
        .tx(tx), .rx(rx), .test_out(test_out), .uart_irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
        step(1);
        hsel = 1'b0; htrans = 2'b00; hwdata = d;
        step(1);
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
        step(1);
        hsel = 1'b0; htrans = 2'b00;
        d = hrdata;
        step(1);
    endtask

    // Serial frame: start, data LSB first, optional parity, stop bit(s).
    task automatic build(input logic [7:0] d, input bit pe, input bit po,
                         input bit ts, input bit flip, input bit stopv);
        fbits = {};
        fbits.push_back(1'b0);
        for (int i = 0; i < 8; i++) fbits.push_back(d[i]);
        if (pe) fbits.push_back((^d) ^ po ^ flip);
        fbits.push_back(stopv);
        if (ts) fbits.push_back(1'b1);
    endtask

    task automatic tx_frame(input logic [7:0] d, input logic [4:0] c);
        int nbad;
        ahb_write(32'h08, {27'd0, c});
        build(d, c[2], c[3], c[4], 1'b0, 1'b1);
        ahb_write(32'h00, {24'd0, d});
        chk("tx_before_fall", tx, 1'b1);
        step(1);
        nbad = 0;
        for (int i = 0; i < fbits.size() * 16; i++) begin
            if (tx !== fbits[i / 16]) nbad++;
            step(1);
        end
        chk("tx_frame_bits", nbad, 0);
        chk("tx_idle_after", tx, 1'b1);
    endtask

    task automatic send_rx(input logic [7:0] d, input bit pe, input bit po,
                           input bit flip, input bit stopv);
        build(d, pe, po, 1'b0, flip, stopv);
        for (int i = 0; i < fbits.size() * 16; i++) begin
            rx_drv = fbits[i / 16];
            step(1);
            trace[i] = irq;
        end
        rx_drv = 1'b1;
        step(20);
    endtask

    task automatic wait_status(input int bitn, input logic val);
        logic [31:0] s;
        int n = 0;
        do begin
            ahb_read(32'h04, s);
            n++;
        end while (s[bitn] !== val && n < 2500);
        chk("status_wait", s[bitn], val);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  d, d1;
        logic [4:0]  c;

        step(3);
        rst_n = 1'b1;
        step(2);
        chk("rst_tx", tx, 1'b1);
        chk("rst_irq", irq, 1'b0);
        chk("rst_test_out", test_out, 8'h00);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("hready", hready, 1'b1);
        chk("hresp", hresp, 1'b0);
        ahb_read(32'h04, r); chk("rst_status", r, 32'h00A);
        ahb_read(32'h0C, r); chk("rst_baud", r, 32'd434);
        ahb_read(32'h08, r); chk("rst_ctrl", r, 32'h3);
        ahb_read(32'h10, r); chk("rst_irq_en", r, 32'h0);
        ahb_read(32'h00, r); chk("empty_data_read", r, 32'h0);

        ahb_write(32'h0C, 32'd2);
        ahb_read(32'h0C, r); chk("baud_min_clamp", r, 32'd4);
        ahb_write(32'h0C, 32'd16);
        ahb_read(32'h0C, r); chk("baud_16", r, 32'd16);
        ahb_write(32'h1C, 32'hFFFF_FFFF);
        ahb_read(32'h1C, r); chk("unmapped_read", r, 32'h0);
        ahb_read(32'h08, r); chk("unmapped_no_write", r, 32'h3);

        tx_frame(8'h55, 5'h03);
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            c = {3'($urandom_range(0, 7)), 2'b11};
            tx_frame(d, c);
        end

        loop_en = 1'b1;
        ahb_write(32'h08, 32'h1F);
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 8'hA3 : 8'($urandom);
            ahb_write(32'h00, {24'd0, d});
            wait_status(3, 1'b0);
            ahb_read(32'h00, r); chk("loop_data", r, {24'd0, d});
            chk("loop_test_out", test_out, d);
            ahb_read(32'h04, r); chk("loop_no_errors", r[8:5], 4'h0);
        end
        step(200);

        loop_en = 1'b0;
        ahb_write(32'h08, 32'h07);
        d1 = 8'($urandom);
        send_rx(d1, 1'b1, 1'b0, 1'b1, 1'b1);
        ahb_read(32'h04, r);
        chk("par_err_set", r[6], 1'b1);
        chk("par_no_frm", r[7], 1'b0);
        ahb_read(32'h00, r); chk("par_char_kept", r, {24'd0, d1});
        chk("par_test_out", test_out, d1);
        send_rx(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        ahb_read(32'h04, r);
        chk("frm_err_set", r[7], 1'b1);
        chk("frm_char_dropped", r[3], 1'b1);
        chk("frm_test_out_held", test_out, d1);
        ahb_write(32'h04, 32'hE0);
        ahb_read(32'h04, r); chk("w1c_clear", r[7:5], 3'b000);

        ahb_write(32'h08, 32'h0F);
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            send_rx(d, 1'b1, 1'b1, 1'b0, 1'b1);
            ahb_read(32'h00, r); chk("odd_par_data", r, {24'd0, d});
            ahb_read(32'h04, r); chk("odd_par_ok", r[7:5], 3'b000);
        end

        ahb_write(32'h08, 32'h02);
        model_q = {};
        for (int k = 0; k < 18; k++) begin
            d = 8'($urandom);
            if (model_q.size() < 16) model_q.push_back(d);
            ahb_write(32'h00, {24'd0, d});
        end
        ahb_read(32'h04, r);
        chk("tx_full", r[0], 1'b1);
        chk("tx_ovf", r[8], 1'b1);
        loop_en = 1'b1;
        ahb_write(32'h08, 32'h03);
        wait_status(1, 1'b1);
        wait_status(4, 1'b0);
        step(20);
        for (int k = 0; k < 16; k++) begin
            ahb_read(32'h00, r);
            chk($sformatf("ovf_char%0d", k), r, {24'd0, model_q[k]});
        end
        ahb_read(32'h04, r);
        chk("ovf_rx_drained", r[3], 1'b1);
        chk("ovf_no_rx_ovr", r[5], 1'b0);
        ahb_write(32'h04, 32'h100);
        ahb_read(32'h04, r); chk("tx_ovf_clear", r[8], 1'b0);

        loop_en = 1'b0;
        ahb_write(32'h10, 32'h1);
        step(1);
        chk("irq_idle", irq, 1'b0);
        d = 8'($urandom);
        send_rx(d, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("irq_before_push", trace[151], 1'b0);
        chk("irq_after_push", trace[155], 1'b1);
        ahb_read(32'h00, r); chk("irq_data", r, {24'd0, d});
        chk("irq_held_pop_cycle", irq, 1'b1);
        step(1);
        chk("irq_drop", irq, 1'b0);

        ahb_write(32'h10, 32'h0);
        ahb_write(32'h00, 32'h00);
        ahb_write(32'h00, 32'h11);
        ahb_write(32'h00, 32'h22);
        step(40);
        chk("mid_frame_low", tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        ahb_read(32'h04, r); chk("rst_fifos_clear", r, 32'h00A);
        ahb_read(32'h0C, r); chk("rst_baud_again", r, 32'd434);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
